// File: rtl/udp_rx_parser_if.sv
// Byte-stream bus of the UDP receive parser: FWFT upstream FIFO read side and downstream FIFO write side.
interface udp_rx_parser_if;
  logic       in_empty;
  logic       in_rd_en;
  logic [7:0] in_dout;
  logic       in_sof;
  logic       in_eof;
  logic       out_full;
  logic       out_wr_en;
  logic [7:0] out_din;
  logic       out_sof;
  logic       out_eof;
  logic       out_err;

  // Parser view: consumes the upstream FIFO, produces payload writes.
  modport slave (
    input  in_empty, in_dout, in_sof, in_eof, out_full,
    output in_rd_en, out_wr_en, out_din, out_sof, out_eof, out_err
  );

  // Environment view: sources frames, sinks payload.
  modport master (
    output in_empty, in_dout, in_sof, in_eof, out_full,
    input  in_rd_en, out_wr_en, out_din, out_sof, out_eof, out_err
  );
endinterface

// File: rtl/udp_rx_parser.sv
// Ethernet/IPv4/UDP receive parser: validates headers and forwards the UDP payload.
module udp_rx_parser #(
  parameter logic [15:0] DST_PORT    = 16'd5000,
  parameter bit          FILTER_EN   = 1'b1,
  parameter bit          CHECKSUM_EN = 1'b1,
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  udp_rx_parser_if.slave         bus,
  output logic [COUNT_WIDTH-1:0] pkt_count,
  output logic [COUNT_WIDTH-1:0] drop_count
);

  localparam int unsigned IDX_W = 11;

  typedef enum logic [2:0] {IDLE, ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, DRAIN} state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [15:0]            csum_q, csum_d;
  logic [7:0]             hi_q, hi_d;
  logic                   bad_q, bad_d;
  logic [15:0]            len_q, len_d;
  logic [15:0]            rem_q, rem_d;
  logic                   first_q, first_d;
  logic [COUNT_WIDTH-1:0] pkt_q, pkt_d;
  logic [COUNT_WIDTH-1:0] drop_q, drop_d;

  logic       rd_c, wr_c, sof_c, eof_c, err_c, hdr_fail;
  logic [7:0] din_c;
  logic [16:0] sum17;

  // Next-state, counters and the combinational FIFO handshakes.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    csum_d   = csum_q;
    hi_d     = hi_q;
    bad_d    = bad_q;
    len_d    = len_q;
    rem_d    = rem_q;
    first_d  = first_q;
    pkt_d    = pkt_q;
    drop_d   = drop_q;
    rd_c     = 1'b0;
    wr_c     = 1'b0;
    din_c    = 8'h00;
    sof_c    = 1'b0;
    eof_c    = 1'b0;
    err_c    = 1'b0;
    sum17    = {1'b0, csum_q} + {1'b0, hi_q, bus.in_dout};
    hdr_fail = bad_q || (CHECKSUM_EN && (csum_q != 16'hFFFF)) || (len_q < 16'd8);

    case (state_q)
      IDLE: begin
        rd_c = !bus.in_empty;
        if (rd_c && bus.in_sof) begin
          // A single-byte frame can never carry a header.
          if (bus.in_eof) begin
            drop_d = drop_q + COUNT_WIDTH'(1);
          end else begin
            state_d = ETH_HDR;
            idx_d   = IDX_W'(1);
            csum_d  = 16'h0000;
            bad_d   = 1'b0;
          end
        end
      end

      ETH_HDR, IP_HDR, UDP_HDR: begin
        rd_c = !bus.in_empty;
        if (rd_c) begin
          // idx 0 here means a payload abort left the new sof byte in the FIFO.
          if (bus.in_sof && (idx_q != IDX_W'(0))) begin
            drop_d  = drop_q + COUNT_WIDTH'(1);
            state_d = ETH_HDR;
            idx_d   = IDX_W'(1);
            csum_d  = 16'h0000;
            bad_d   = 1'b0;
          end else if (bus.in_eof) begin
            drop_d  = drop_q + COUNT_WIDTH'(1);
            state_d = IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            case (idx_q)
              IDX_W'(12): if (bus.in_dout != 8'h08) bad_d = 1'b1;
              IDX_W'(13): if (bus.in_dout != 8'h00) bad_d = 1'b1;
              IDX_W'(14): if (bus.in_dout != 8'h45) bad_d = 1'b1;
              IDX_W'(23): if (bus.in_dout != 8'h11) bad_d = 1'b1;
              IDX_W'(36): if (FILTER_EN && (bus.in_dout != DST_PORT[15:8])) bad_d = 1'b1;
              IDX_W'(37): if (FILTER_EN && (bus.in_dout != DST_PORT[7:0])) bad_d = 1'b1;
              IDX_W'(38): len_d = {bus.in_dout, len_q[7:0]};
              IDX_W'(39): len_d = {len_q[15:8], bus.in_dout};
              default: ;
            endcase
            // Even bytes latch the high half, odd bytes fold the 16-bit word with end-around carry.
            if ((idx_q >= IDX_W'(14)) && (idx_q <= IDX_W'(33))) begin
              if (!idx_q[0]) hi_d = bus.in_dout;
              else           csum_d = sum17[15:0] + 16'(sum17[16]);
            end
            if (idx_q == IDX_W'(13)) begin
              state_d = IP_HDR;
            end else if (idx_q == IDX_W'(33)) begin
              state_d = UDP_HDR;
            end else if (idx_q == IDX_W'(41)) begin
              if (hdr_fail) begin
                drop_d  = drop_q + COUNT_WIDTH'(1);
                state_d = DRAIN;
              end else if (len_q == 16'd8) begin
                pkt_d   = pkt_q + COUNT_WIDTH'(1);
                state_d = DRAIN;
              end else begin
                rem_d   = len_q - 16'd8;
                first_d = 1'b1;
                state_d = PAYLOAD;
              end
            end
          end
        end
      end

      PAYLOAD: begin
        if (!bus.in_empty && bus.in_sof) begin
          // Close the truncated payload with a marker byte; the sof byte stays for the header path.
          if (!bus.out_full) begin
            wr_c    = 1'b1;
            eof_c   = 1'b1;
            err_c   = 1'b1;
            drop_d  = drop_q + COUNT_WIDTH'(1);
            state_d = ETH_HDR;
            idx_d   = IDX_W'(0);
            csum_d  = 16'h0000;
            bad_d   = 1'b0;
          end
        end else begin
          rd_c  = !bus.in_empty && !bus.out_full;
          wr_c  = rd_c;
          din_c = bus.in_dout;
          if (rd_c) begin
            sof_c   = first_q;
            first_d = 1'b0;
            rem_d   = rem_q - 16'd1;
            if (rem_q == 16'd1) begin
              eof_c   = 1'b1;
              pkt_d   = pkt_q + COUNT_WIDTH'(1);
              state_d = bus.in_eof ? IDLE : DRAIN;
            end else if (bus.in_eof) begin
              eof_c   = 1'b1;
              err_c   = 1'b1;
              drop_d  = drop_q + COUNT_WIDTH'(1);
              state_d = IDLE;
            end
          end
        end
      end

      DRAIN: begin
        rd_c = !bus.in_empty;
        if (rd_c) begin
          if (bus.in_sof) begin
            drop_d  = drop_q + COUNT_WIDTH'(1);
            state_d = ETH_HDR;
            idx_d   = IDX_W'(1);
            csum_d  = 16'h0000;
            bad_d   = 1'b0;
          end else if (bus.in_eof) begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Handshakes are quiet while reset is held.
    if (!reset) begin
      rd_c  = 1'b0;
      wr_c  = 1'b0;
      din_c = 8'h00;
      sof_c = 1'b0;
      eof_c = 1'b0;
      err_c = 1'b0;
    end
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      csum_q  <= '0;
      hi_q    <= '0;
      bad_q   <= 1'b0;
      len_q   <= '0;
      rem_q   <= '0;
      first_q <= 1'b0;
      pkt_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      hi_q    <= hi_d;
      bad_q   <= bad_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
      first_q <= first_d;
      pkt_q   <= pkt_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.in_rd_en  = rd_c;
  assign bus.out_wr_en = wr_c;
  assign bus.out_din   = din_c;
  assign bus.out_sof   = sof_c;
  assign bus.out_eof   = eof_c;
  assign bus.out_err   = err_c;
  assign pkt_count     = pkt_q;
  assign drop_count    = drop_q;

endmodule
